// File: rtl/riscv_pkg.sv
// Shared definitions for the front-end pipeline.
//   XLEN      : default PC/address width
//   INST_W    : instruction word width
//   RESET_PC  : default PC loaded on reset
//   NOP       : canonical NOP encoding (addi x0, x0, 0)
//   fetch_state_e : fetch FSM states (HALT only reachable with IF_MISALIGN_CHECK_EN)
package riscv_pkg;

  localparam int unsigned XLEN     = 64;
  localparam int unsigned INST_W   = 32;
  localparam logic [63:0] RESET_PC = 64'h0;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO used for the fetch instruction buffer and the issued-PC tag queue.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   push/push_data : write an entry (accepted when not full, or full with a same-cycle pop)
//   pop          : remove the head entry (ignored when empty)
//   flush        : empty the FIFO; takes priority over push/pop
//   head         : current head entry (registered storage)
//   full/empty/count : occupancy status
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 96
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: holds the PC, issues in-order word requests to instruction
// memory, buffers returned words with their PC and hands {pc, instruction} to decode.
// Redirects from execute flush the buffer and drop wrong-path responses.
// Optional feature macro: IF_MISALIGN_CHECK_EN (misaligned redirect -> sticky
// fetch_misalign flag and HALT until an aligned redirect).
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   imem_req_valid/ready/addr     : word request channel to instruction memory
//   imem_resp_valid/data          : in-order response channel
//   redirect_valid/pc             : branch/jump redirect pulse from execute
//   inst_valid/ready/data/pc      : instruction handshake to decode
//   fetch_misalign                : sticky misaligned-redirect flag (macro builds only)
module instr_fetch
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN       = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(riscv_pkg::RESET_PC),
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [INST_W-1:0] imem_resp_data,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_data,
  output logic [XLEN-1:0]   inst_pc
`ifdef IF_MISALIGN_CHECK_EN
  ,
  output logic              fetch_misalign
`endif
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned EW = XLEN + INST_W;

  fetch_state_e    state;
  logic [XLEN-1:0] pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   occupancy;
  logic [CW+1:0]   inflight;
  logic            req_fire;
  logic            resp_drop;
  logic            resp_push;
  logic            inst_pop;
  logic [XLEN-1:0] target_pc;
  logic            redirect_misaligned;
  logic [XLEN-1:0] tag_pc;
  logic [EW-1:0]   buf_head;
  logic            buf_empty;
  logic            buf_full_unused;
  logic            tag_full_unused;
  logic            tag_empty_unused;
  logic [CW-1:0]   tag_count_unused;

  assign target_pc = {redirect_pc[XLEN-1:2], 2'b00};

`ifdef IF_MISALIGN_CHECK_EN
  assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);
`else
  logic pc_lsbs_unused;
  assign pc_lsbs_unused      = ^redirect_pc[1:0];
  assign redirect_misaligned = 1'b0;
`endif

  // Credit: every buffered, in-flight or to-be-dropped word holds one buffer slot.
  assign inflight       = (CW+2)'(occupancy) + (CW+2)'(outstanding) + (CW+2)'(drop_cnt);
  assign imem_req_valid = (state == FETCH) && (inflight < (CW+2)'(FIFO_DEPTH));
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign resp_drop      = imem_resp_valid && (drop_cnt != '0);
  assign resp_push      = imem_resp_valid && (drop_cnt == '0) && !redirect_valid;
  assign inst_pop       = inst_valid && inst_ready && !redirect_valid;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (XLEN)
  ) u_tag_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (req_fire && !redirect_valid),
    .push_data (pc),
    .pop       (resp_push),
    .flush     (redirect_valid),
    .head      (tag_pc),
    .full      (tag_full_unused),
    .empty     (tag_empty_unused),
    .count     (tag_count_unused)
  );

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_inst_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (resp_push),
    .push_data ({tag_pc, imem_resp_data}),
    .pop       (inst_pop),
    .flush     (redirect_valid),
    .head      (buf_head),
    .full      (buf_full_unused),
    .empty     (buf_empty),
    .count     (occupancy)
  );

  assign inst_valid = !buf_empty;
  assign inst_data  = inst_valid ? buf_head[INST_W-1:0] : '0;
  assign inst_pc    = inst_valid ? buf_head[EW-1:INST_W] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (redirect_valid) begin
      // Everything still owed by memory becomes wrong-path: old drops, outstanding
      // requests and a request accepted now, less the response consumed this cycle.
      drop_cnt    <= drop_cnt + outstanding + CW'(req_fire) - CW'(imem_resp_valid);
      outstanding <= '0;
      pc          <= target_pc;
      state       <= redirect_misaligned ? HALT : FETCH;
    end else begin
      if (state == IDLE) state <= FETCH;
      if (req_fire) pc <= pc + XLEN'(4);
      outstanding <= outstanding + CW'(req_fire) - CW'(resp_push);
      if (resp_drop) drop_cnt <= drop_cnt - CW'(1);
    end
  end

`ifdef IF_MISALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fetch_misalign <= 1'b0;
    else if (redirect_valid && redirect_misaligned) fetch_misalign <= 1'b1;
  end
`endif

  resp_needs_request: assert property (@(posedge clk) disable iff (!rst_n)
    imem_resp_valid |-> (outstanding != '0 || drop_cnt != '0));

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  // main DUT (RESET_PC = 0)
  logic        req_valid, req_ready, resp_valid, redirect_valid, inst_valid, inst_ready;
  logic [63:0] req_addr, redirect_pc, inst_pc;
  logic [31:0] resp_data, inst_data;
`ifdef IF_MISALIGN_CHECK_EN
  logic        fetch_misalign;
  logic        w_fetch_misalign;
`endif

  // wrap DUT (RESET_PC near the top of the address space)
  logic        w_req_valid, w_req_ready, w_resp_valid, w_redirect_valid, w_inst_valid, w_inst_ready;
  logic [63:0] w_req_addr, w_redirect_pc, w_inst_pc;
  logic [31:0] w_resp_data, w_inst_data;

  instr_fetch #(.XLEN(64), .RESET_PC(64'h0), .FIFO_DEPTH(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
    .imem_resp_valid(resp_valid), .imem_resp_data(resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc)
`ifdef IF_MISALIGN_CHECK_EN
    , .fetch_misalign(fetch_misalign)
`endif
  );

  instr_fetch #(.XLEN(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFF8), .FIFO_DEPTH(2)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready), .imem_req_addr(w_req_addr),
    .imem_resp_valid(w_resp_valid), .imem_resp_data(w_resp_data),
    .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
    .inst_valid(w_inst_valid), .inst_ready(w_inst_ready), .inst_data(w_inst_data), .inst_pc(w_inst_pc)
`ifdef IF_MISALIGN_CHECK_EN
    , .fetch_misalign(w_fetch_misalign)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'hC0DE_0000;
  endfunction

  // memory models and decode-side monitors (drive on negedge, sample 1 time unit later)
  int          cyc = 0;
  int          lat = 1;
  int          acc_cnt = 0;
  logic [63:0] mq_addr[$];
  int          mq_due[$];
  logic [63:0] acc_addr[$];
  logic [63:0] got_pc[$];
  logic [31:0] got_data[$];
  logic        w_pend = 1'b0;
  logic [63:0] w_pend_addr = '0;
  logic [63:0] w_acc[$];
  logic [63:0] w_got[$];

  always @(negedge clk) begin
    cyc++;
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      resp_valid = 1'b1;
      resp_data  = mem_word(mq_addr[0]);
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end else begin
      resp_valid = 1'b0;
      resp_data  = '0;
    end
    w_resp_valid = w_pend;
    w_resp_data  = mem_word(w_pend_addr);
    #1;
    if (rst_n) begin
      if (req_valid && req_ready) begin
        mq_addr.push_back(req_addr);
        mq_due.push_back(cyc + lat);
        acc_addr.push_back(req_addr);
        acc_cnt++;
      end
      if (inst_valid && inst_ready && !redirect_valid) begin
        got_pc.push_back(inst_pc);
        got_data.push_back(inst_data);
      end
      w_pend      = w_req_valid && w_req_ready;
      w_pend_addr = w_req_addr;
      if (w_pend) w_acc.push_back(w_req_addr);
      if (w_inst_valid && w_inst_ready) w_got.push_back(w_inst_pc);
    end else begin
      w_pend = 1'b0;
    end
  end

  logic [63:0] exp_pc;

  task automatic check_next(input int n, input string tag);
    int          budget;
    logic [63:0] p;
    logic [31:0] d;
    for (int i = 0; i < n; i++) begin
      budget = 0;
      while (got_pc.size() == 0 && budget < 200) begin
        @(negedge clk); #2;
        budget++;
      end
      if (got_pc.size() == 0) begin
        check_eq({tag, "_timeout"}, 64'(got_pc.size()), 64'd1);
        return;
      end
      p = got_pc.pop_front();
      d = got_data.pop_front();
      check_eq($sformatf("%s_pc%0d", tag, i), p, exp_pc);
      check_eq($sformatf("%s_data%0d", tag, i), 64'(d), 64'(mem_word(exp_pc)));
      exp_pc = exp_pc + 64'd4;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          base;
    int          idx;
    int          k;
    logic [63:0] a;

    rst_n = 1'b0;
    req_ready = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    w_req_ready = 1'b0; w_inst_ready = 1'b0; w_redirect_valid = 1'b0; w_redirect_pc = '0;
    resp_valid = 1'b0; resp_data = '0; w_resp_valid = 1'b0; w_resp_data = '0;

    // reset state
    repeat (3) @(negedge clk);
    #2;
    check_eq("rst_req_valid",  64'(req_valid),  64'd0);
    check_eq("rst_inst_valid", 64'(inst_valid), 64'd0);
    check_eq("rst_inst_data",  64'(inst_data),  64'd0);
    check_eq("rst_inst_pc",    inst_pc,         64'd0);
    check_eq("rst_req_addr",   req_addr,        64'd0);
    check_eq("rst_wrap_addr",  w_req_addr,      64'hFFFF_FFFF_FFFF_FFF8);

    @(negedge clk);
    rst_n = 1'b1;
    req_ready = 1'b1; inst_ready = 1'b1; w_req_ready = 1'b1; w_inst_ready = 1'b1;
    #2;
    check_eq("idle_no_req", 64'(req_valid), 64'd0);
    @(negedge clk); #2;
    check_eq("fetch_req_valid", 64'(req_valid), 64'd1);
    check_eq("fetch_req_addr",  req_addr,       64'd0);

    // streaming with 1-cycle memory
    exp_pc = 64'd0;
    check_next(4, "seq");
    @(negedge clk); req_ready = 1'b0;
    repeat (8) @(negedge clk);
    check_next(got_pc.size(), "drain1");

    // request held while memory stalls
    #2;
    check_eq("hold_valid0", 64'(req_valid), 64'd1);
    check_eq("hold_addr0",  req_addr,       exp_pc);
    @(negedge clk); #2;
    check_eq("hold_valid1", 64'(req_valid), 64'd1);
    check_eq("hold_addr1",  req_addr,       exp_pc);

    // decode stall: only FIFO_DEPTH requests may be accepted
    @(negedge clk);
    req_ready = 1'b1; inst_ready = 1'b0;
    base = acc_cnt;
    repeat (10) @(negedge clk);
    #2;
    check_eq("stall_accepts",   64'(acc_cnt - base), 64'd2);
    check_eq("stall_req_valid", 64'(req_valid),      64'd0);
    check_eq("stall_inst_valid", 64'(inst_valid),    64'd1);
    check_eq("stall_head_pc",   inst_pc,             exp_pc);
    @(negedge clk); inst_ready = 1'b1;
    check_next(6, "resume");
    @(negedge clk); req_ready = 1'b0;
    repeat (8) @(negedge clk);
    check_next(got_pc.size(), "drain2");

    // 3-cycle memory, redirect with two requests outstanding
    lat = 3;
    base = acc_cnt;
    @(negedge clk); req_ready = 1'b1;
    k = 0;
    while (acc_cnt - base < 2 && k < 20) begin
      @(negedge clk); #2;
      k++;
    end
    check_eq("redir_two_out", 64'(acc_cnt - base), 64'd2);
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 64'h100;
    #2;
    check_eq("redir_credit_block", 64'(req_valid), 64'd0);
    idx = acc_addr.size();
    @(negedge clk); redirect_valid = 1'b0;
    exp_pc = 64'h100;
    check_next(2, "redir");
    a = acc_addr[idx];
    check_eq("redir_first_req", a, 64'h100);
    @(negedge clk); req_ready = 1'b0;
    repeat (12) @(negedge clk);
    check_next(got_pc.size(), "drain3");

    // redirect coinciding with response push and decode pop
    @(negedge clk); req_ready = 1'b1; inst_ready = 1'b0;
    k = 0;
    while (!inst_valid && k < 20) begin
      @(negedge clk); #2;
      k++;
    end
    check_eq("coll_head_pc", inst_pc, exp_pc);
    inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h300;
    idx = acc_addr.size();
    @(negedge clk); redirect_valid = 1'b0;
    #2;
    check_eq("coll_flushed",   64'(inst_valid), 64'd0);
    check_eq("coll_req_valid", 64'(req_valid),  64'd1);
    check_eq("coll_req_addr",  req_addr,        64'h300);
    exp_pc = 64'h300;
    check_next(2, "coll");
    a = acc_addr[idx];
    check_eq("coll_first_req", a, 64'h300);

    // PC wrap on the second instance
    check_eq("wrap_acc_count", 64'(w_acc.size() >= 3), 64'd1);
    check_eq("wrap_got_count", 64'(w_got.size() >= 3), 64'd1);
    if (w_acc.size() >= 3 && w_got.size() >= 3) begin
      a = w_acc[0]; check_eq("wrap_req0", a, 64'hFFFF_FFFF_FFFF_FFF8);
      a = w_acc[1]; check_eq("wrap_req1", a, 64'hFFFF_FFFF_FFFF_FFFC);
      a = w_acc[2]; check_eq("wrap_req2", a, 64'h0);
      a = w_got[0]; check_eq("wrap_pc0",  a, 64'hFFFF_FFFF_FFFF_FFF8);
      a = w_got[1]; check_eq("wrap_pc1",  a, 64'hFFFF_FFFF_FFFF_FFFC);
      a = w_got[2]; check_eq("wrap_pc2",  a, 64'h0);
    end

`ifdef IF_MISALIGN_CHECK_EN
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 64'h102;
    @(negedge clk); redirect_valid = 1'b0;
    #2;
    check_eq("mis_flag",      64'(fetch_misalign), 64'd1);
    check_eq("mis_req_valid", 64'(req_valid),      64'd0);
    base = acc_cnt;
    repeat (6) @(negedge clk);
    check_eq("mis_no_reqs", 64'(acc_cnt - base), 64'd0);
    got_pc.delete(); got_data.delete();
    redirect_valid = 1'b1; redirect_pc = 64'h200;
    @(negedge clk); redirect_valid = 1'b0;
    exp_pc = 64'h200;
    check_next(2, "mis_resume");
    check_eq("mis_flag_sticky", 64'(fetch_misalign), 64'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
